// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, enable modes, mode classes and the mode decoder.
package alu_pkg;

  typedef enum logic [1:0] {
    OP1 = 2'd0,
    OP2 = 2'd1,
    OP3 = 2'd2,
    OP4 = 2'd3
  } opcode_t;

  // {alu_enable_b, alu_enable_a, alu_enable}
  typedef logic [2:0] mode_t;

  localparam mode_t ENABLE_MODE_A = 3'b011;
  localparam mode_t ENABLE_MODE_B = 3'b101;

  typedef enum logic [1:0] {
    MODE_CLASS_OFF     = 2'd0,
    MODE_CLASS_A       = 2'd1,
    MODE_CLASS_B       = 2'd2,
    MODE_CLASS_ILLEGAL = 2'd3
  } mode_class_t;

  // Global enable low wins; otherwise exactly one of A/B must be selected.
  function automatic mode_class_t decode_mode(input mode_t mode);
    mode_class_t cls;
    if (!mode[0])                    cls = MODE_CLASS_OFF;
    else if (mode == ENABLE_MODE_A)  cls = MODE_CLASS_A;
    else if (mode == ENABLE_MODE_B)  cls = MODE_CLASS_B;
    else                             cls = MODE_CLASS_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO; depth must be a power of two so pointers wrap freely.
module alu_result_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe_p.sv
// Two-stage pipelined ALU with credit-based input flow control and a result FIFO.
module alu_pipe_p
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_enable,
  input  logic              alu_enable_a,
  input  logic              alu_enable_b,
  input  logic [1:0]        alu_op_a,
  input  logic [1:0]        alu_op_b,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_err,
  output logic              alu_irq,
  input  logic              alu_irq_clr
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } alu_result_t;

  mode_class_t       w_class;
  logic              w_s1_load;
  opcode_t           w_op;
  logic              r_s1_valid;
  mode_class_t       r_s1_class;
  opcode_t           r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [DATA_W:0]   w_sum;
  alu_result_t       w_res;
  logic              w_irq_set;
  logic              r_s2_valid;
  alu_result_t       r_s2_res;
  logic              r_s2_irq;
  alu_result_t       w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic [CRD_W-1:0]  w_credit_next;
  logic              r_in_ready;
  logic              r_alu_irq;

  assign w_class   = decode_mode({alu_enable_b, alu_enable_a, alu_enable});
  assign w_s1_load = in_valid && r_in_ready && (w_class != MODE_CLASS_OFF);
  assign w_op      = (w_class == MODE_CLASS_B) ? opcode_t'(alu_op_b) : opcode_t'(alu_op_a);
  assign w_pop     = !w_fifo_empty && out_ready;

  // Stage 1: capture operands and decoded mode; disabled requests leave no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_class <= MODE_CLASS_OFF;
      r_s1_op    <= OP1;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= w_s1_load;
      if (w_s1_load) begin
        r_s1_class <= w_class;
        r_s1_op    <= w_op;
        r_s1_a     <= alu_in_a;
        r_s1_b     <= alu_in_b;
      end
    end
  end

  assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};

  // Stage 2 datapath: result plus the carry/borrow/illegal interrupt cause.
  always_comb begin
    w_res     = '0;
    w_irq_set = 1'b0;
    case (r_s1_class)
      MODE_CLASS_A: begin
        case (r_s1_op)
          OP1: begin
            w_res.data = w_sum[DATA_W-1:0];
            w_irq_set  = w_sum[DATA_W];
          end
          OP2: begin
            w_res.data = r_s1_a - r_s1_b;
            w_irq_set  = (r_s1_a < r_s1_b);
          end
          OP3: w_res.data = r_s1_a & r_s1_b;
          OP4: w_res.data = r_s1_a ^ r_s1_b;
        endcase
      end
      MODE_CLASS_B: begin
        case (r_s1_op)
          OP1: w_res.data = r_s1_a | r_s1_b;
          OP2: w_res.data = ~(r_s1_a & r_s1_b);
          OP3: w_res.data = r_s1_a << r_s1_b[SH_W-1:0];
          OP4: w_res.data = (r_s1_a > r_s1_b) ? r_s1_a : r_s1_b;
        endcase
      end
      MODE_CLASS_ILLEGAL: begin
        w_res.err = 1'b1;
        w_irq_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage 2 register feeding the FIFO push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_irq   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_res   <= w_res;
      r_s2_irq   <= w_irq_set;
    end
  end

  alu_result_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_s2_valid),
    .i_push_data (r_s2_res),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Credits after this edge: queued results plus everything still in the pipe.
  assign w_credit_next = CRD_W'(w_fifo_count) + CRD_W'(r_s2_valid) + CRD_W'(r_s1_valid)
                       + CRD_W'(w_s1_load) - CRD_W'(w_pop);

  // Registered ready so it reads low during reset and rises one edge later.
  always_ff @(posedge clk) begin
    if (reset) r_in_ready <= 1'b0;
    else       r_in_ready <= (w_credit_next < CRD_W'(OUT_DEPTH));
  end

  // Sticky interrupt: a set on FIFO entry beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                       r_alu_irq <= 1'b0;
    else if (r_s2_valid && r_s2_irq) r_alu_irq <= 1'b1;
    else if (alu_irq_clr)            r_alu_irq <= 1'b0;
  end

  // Credit accounting guarantees a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset && r_s2_valid) assert (!w_fifo_full);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = !w_fifo_empty;
  assign alu_out   = w_head.data;
  assign alu_err   = w_head.err;
  assign alu_irq   = r_alu_irq;

endmodule
